// File: rtl/test_i5160_pkg.sv
// -----------------------------------------------------------------------------
// test_i5160_pkg
//
// Shared definitions for the I5160 sink stage and its siblings:
//   - state_t     : FSM state encoding (IDLE, ARM, COUNT, FIRE)
//   - *_DEF       : default values for the counter/timer parameters
// -----------------------------------------------------------------------------
package test_i5160_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARM   = 2'd1,
    COUNT = 2'd2,
    FIRE  = 2'd3
  } state_t;

  // Width of the edge counter and of the count output.
  localparam int CNT_W_DEF  = 4;
  // Rising edges needed to fire.
  localparam int THRESH_DEF = 3;
  // Width of the inactivity timer.
  localparam int WIN_W_DEF  = 5;
  // Maximum cycles allowed between counted edges.
  localparam int WINDOW_DEF = 16;

endpackage : test_i5160_pkg

// File: rtl/test_i5160_edge.sv
// -----------------------------------------------------------------------------
// test_i5160_edge
//
// Rising-edge detector shared by the sink stages. The input is captured into
// a sample register (s0) and then a history register (s1); a rising edge is
// reported for the one cycle in which s0 is high and s1 is still low. A level
// held high therefore yields exactly one edge, and it must be sampled low at
// least once before another edge can be reported.
//
// Ports:
//   clk    in  1  rising-edge clock
//   rst_n  in  1  asynchronous active-low reset
//   din    in  1  raw input level
//   rise   out 1  one-cycle rising-edge indication (s0 & ~s1)
// -----------------------------------------------------------------------------
module test_i5160_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic rise
);

  logic s0;
  logic s1;

  // NOTE: state flops use non-blocking assignments so s1 takes the old s0;
  // a blocking assignment here would collapse the pair into a single stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s0 <= 1'b0;
      s1 <= 1'b0;
    end else begin
      s0 <= din;
      s1 <= s0;
    end
  end

  assign rise = s0 & ~s1;

endmodule : test_i5160_edge

// File: rtl/test_i5160_sink.sv
// -----------------------------------------------------------------------------
// test_i5160_sink
//
// Downstream consumer of the I4725 qualified net. While armed by I2557 it
// counts rising edges of I4725; the gap between counted edges must stay below
// WINDOW cycles or the run is abandoned. On the THRESH-th edge it raises
// I5160 for exactly one cycle, then clears and re-arms.
//
// Parameters:
//   CNT_W   width of the edge counter and of I5161
//   THRESH  edges required to fire       (2 <= THRESH <= 2^CNT_W-1)
//   WIN_W   width of the inactivity timer
//   WINDOW  max cycles between edges     (1 <= WINDOW <= 2^WIN_W-1)
//
// Ports:
//   I1470_clk  in  1      clock, rising edge
//   I1477_rst  in  1      asynchronous active-low reset
//   I4725      in  1      upstream event net, may toggle every cycle
//   I2557      in  1      arm enable, level-sensitive, sampled directly
//   I5160      out 1      fire flag, one cycle, decoded from the state flops
//   I5161      out CNT_W  current edge count (count register)
// -----------------------------------------------------------------------------
module test_i5160_sink
  import test_i5160_pkg::*;
#(
  parameter int CNT_W  = CNT_W_DEF,
  parameter int THRESH = THRESH_DEF,
  parameter int WIN_W  = WIN_W_DEF,
  parameter int WINDOW = WINDOW_DEF
) (
  input  logic             I1470_clk,
  input  logic             I1477_rst,
  input  logic             I4725,
  input  logic             I2557,
  output logic             I5160,
  output logic [CNT_W-1:0] I5161
);

  // ---------------------------------------------------------------------------
  // Parameter legality, checked at elaboration
  // ---------------------------------------------------------------------------
  if (THRESH < 2 || THRESH > (2 ** CNT_W) - 1) begin : g_bad_thresh
    $error("test_i5160_sink: THRESH=%0d outside [2, 2^CNT_W-1]", THRESH);
  end

  if (WINDOW < 1 || WINDOW > (2 ** WIN_W) - 1) begin : g_bad_window
    $error("test_i5160_sink: WINDOW=%0d outside [1, 2^WIN_W-1]", WINDOW);
  end

  localparam logic [CNT_W-1:0] THRESH_C    = CNT_W'(THRESH);
  localparam logic [CNT_W-1:0] THRESH_M1   = CNT_W'(THRESH - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO    = '0;
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  localparam logic [WIN_W-1:0] TIMER_LAST  = WIN_W'(WINDOW - 1);
  localparam logic [WIN_W-1:0] TIMER_ZERO  = '0;

  // ---------------------------------------------------------------------------
  // Edge detection on the event net
  // ---------------------------------------------------------------------------
  logic rise;

  test_i5160_edge u_edge (
    .clk   (I1470_clk),
    .rst_n (I1477_rst),
    .din   (I4725),
    .rise  (rise)
  );

  // ---------------------------------------------------------------------------
  // FSM, edge counter and inactivity timer
  // ---------------------------------------------------------------------------
  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_nxt;
  logic [WIN_W-1:0] timer;
  logic [WIN_W-1:0] timer_nxt;

  always_ff @(posedge I1470_clk or negedge I1477_rst) begin
    if (!I1477_rst) begin
      state <= IDLE;
      count <= CNT_ZERO;
      timer <= TIMER_ZERO;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
      timer <= timer_nxt;
    end
  end

  // Priority inside each state: enable drop, then edge, then timeout.
  // The timer only advances while in COUNT; every other path clears it.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    state_nxt = state;
    count_nxt = count;
    timer_nxt = TIMER_ZERO;

    unique case (state)
      IDLE: begin
        count_nxt = CNT_ZERO;
        if (I2557) state_nxt = ARM;
      end

      ARM: begin
        count_nxt = CNT_ZERO;
        if (!I2557) begin
          state_nxt = IDLE;
        end else if (rise) begin
          count_nxt = CNT_ONE;
          state_nxt = COUNT;
        end
      end

      COUNT: begin
        if (!I2557) begin
          count_nxt = CNT_ZERO;
          state_nxt = IDLE;
        end else if (rise && count == THRESH_M1) begin
          count_nxt = THRESH_C;
          state_nxt = FIRE;
        end else if (rise) begin
          count_nxt = count + 1'b1;
        end else if (timer == TIMER_LAST) begin
          // No edge for WINDOW cycles: abandon the run, stay armed.
          count_nxt = CNT_ZERO;
          state_nxt = ARM;
        end else begin
          timer_nxt = timer + 1'b1;
        end
      end

      FIRE: begin
        if (!I2557) begin
          count_nxt = CNT_ZERO;
          state_nxt = IDLE;
        end else if (rise) begin
          // The edge opens the next run rather than being dropped.
          count_nxt = CNT_ONE;
          state_nxt = COUNT;
        end else begin
          count_nxt = CNT_ZERO;
          state_nxt = ARM;
        end
      end

      default: begin
        count_nxt = CNT_ZERO;
        state_nxt = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs come straight from the state and count flops
  // ---------------------------------------------------------------------------
  assign I5160 = (state == FIRE);
  assign I5161 = count;

endmodule : test_i5160_sink

// File: tb/tb_test_i5160_sink.sv
// -----------------------------------------------------------------------------
// tb_test_i5160_sink
//
// Directed bench for test_i5160_sink with default parameters (CNT_W=4,
// THRESH=3, WIN_W=5, WINDOW=16). Inputs change and outputs are observed just
// after the falling clock edge, half a cycle away from the active edge.
// An input driven high before rising edge k is captured at k, the FSM acts on
// it at k+1, so a one-cycle pulse driven at one falling edge is visible in the
// count two falling edges later.
// -----------------------------------------------------------------------------
module tb_test_i5160_sink;
  import test_i5160_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       ev;
  logic       en;
  logic       fire;
  logic [3:0] cnt;

  int tests_run;
  int tests_failed;

  test_i5160_sink dut (
    .I1470_clk (clk),
    .I1477_rst (rst_n),
    .I4725     (ev),
    .I2557     (en),
    .I5160     (fire),
    .I5161     (cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One-cycle pulse on I4725; returns at the point where its edge is counted.
  task automatic pulse();
    ev = 1'b1;
    step(1);
    ev = 1'b0;
    step(1);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    ev    = 1'b0;
    en    = 1'b0;
    step(2);
    tests_run++;
    if (fire !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_fire: got %b want 0", fire);
    end
    tests_run++;
    if (cnt !== 4'd0) begin
      tests_failed++;
      $display("FAIL reset_count: got %0d want 0", cnt);
    end
    tests_run++;
    if (dut.state !== IDLE) begin
      tests_failed++;
      $display("FAIL reset_state: got %0d want %0d", dut.state, IDLE);
    end
    rst_n = 1'b1;
    step(1);
  endtask

  task automatic test_basic_fire();
    en = 1'b1;
    step(1);
    tests_run++;
    if (dut.state !== ARM) begin
      tests_failed++;
      $display("FAIL basic_arm: got state %0d want %0d", dut.state, ARM);
    end
    pulse();
    tests_run++;
    if (cnt !== 4'd1) begin
      tests_failed++;
      $display("FAIL basic_count1: got %0d want 1", cnt);
    end
    step(1);
    pulse();
    tests_run++;
    if (cnt !== 4'd2) begin
      tests_failed++;
      $display("FAIL basic_count2: got %0d want 2", cnt);
    end
    step(1);
    pulse();
    tests_run++;
    if (fire !== 1'b1 || cnt !== 4'd3) begin
      tests_failed++;
      $display("FAIL basic_fire: got fire=%b count=%0d want fire=1 count=3", fire, cnt);
    end
    step(1);
    tests_run++;
    if (fire !== 1'b0 || cnt !== 4'd0 || dut.state !== ARM) begin
      tests_failed++;
      $display("FAIL basic_rearm: got fire=%b count=%0d state=%0d want 0/0/%0d",
               fire, cnt, dut.state, ARM);
    end
  endtask

  task automatic test_held_input();
    int bad_fire = 0;
    ev = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step(1);
      if (fire !== 1'b0) bad_fire++;
    end
    tests_run++;
    if (cnt !== 4'd1) begin
      tests_failed++;
      $display("FAIL held_count: got %0d want 1", cnt);
    end
    tests_run++;
    if (bad_fire !== 0) begin
      tests_failed++;
      $display("FAIL held_nofire: got %0d fire cycles want 0", bad_fire);
    end
    ev = 1'b0;
    en = 1'b0;
    step(1);
    tests_run++;
    if (dut.state !== IDLE || cnt !== 4'd0) begin
      tests_failed++;
      $display("FAIL held_disarm: got state=%0d count=%0d want %0d/0", dut.state, cnt, IDLE);
    end
  endtask

  task automatic test_timeout();
    en = 1'b1;
    step(1);
    pulse();
    step(1);
    pulse();
    // Last counted edge just landed; 15 quiet cycles keep the run alive.
    step(15);
    tests_run++;
    if (cnt !== 4'd2 || dut.state !== COUNT) begin
      tests_failed++;
      $display("FAIL timeout_edge15: got count=%0d state=%0d want 2/%0d", cnt, dut.state, COUNT);
    end
    step(1);
    tests_run++;
    if (cnt !== 4'd0 || dut.state !== ARM) begin
      tests_failed++;
      $display("FAIL timeout_edge16: got count=%0d state=%0d want 0/%0d", cnt, dut.state, ARM);
    end
    pulse();
    tests_run++;
    if (cnt !== 4'd1 || fire !== 1'b0) begin
      tests_failed++;
      $display("FAIL timeout_restart: got count=%0d fire=%b want 1/0", cnt, fire);
    end
    en = 1'b0;
    step(2);
  endtask

  task automatic test_enable_vs_edge();
    en = 1'b1;
    step(1);
    pulse();
    step(1);
    pulse();
    step(1);
    ev = 1'b1;
    step(1);
    // Third edge is live this cycle, but the enable drops at the same time.
    ev = 1'b0;
    en = 1'b0;
    step(1);
    tests_run++;
    if (fire !== 1'b0 || cnt !== 4'd0 || dut.state !== IDLE) begin
      tests_failed++;
      $display("FAIL enable_drop: got fire=%b count=%0d state=%0d want 0/0/%0d",
               fire, cnt, dut.state, IDLE);
    end
    step(1);
    tests_run++;
    if (fire !== 1'b0) begin
      tests_failed++;
      $display("FAIL enable_nofire_late: got %b want 0", fire);
    end
  endtask

  // A new pulse arriving in the FIRE cycle must not suppress the fire and must
  // open the next run once the edge detector reports it.
  task automatic test_edge_during_fire();
    en = 1'b1;
    step(1);
    pulse();
    step(1);
    pulse();
    step(1);
    ev = 1'b1;
    step(1);
    ev = 1'b0;
    step(1);
    ev = 1'b1;          // arrives while in FIRE
    tests_run++;
    if (fire !== 1'b1 || cnt !== 4'd3) begin
      tests_failed++;
      $display("FAIL fire_edge_pulse: got fire=%b count=%0d want 1/3", fire, cnt);
    end
    step(1);
    ev = 1'b0;
    tests_run++;
    if (fire !== 1'b0) begin
      tests_failed++;
      $display("FAIL fire_edge_single: got %b want 0", fire);
    end
    step(1);
    tests_run++;
    if (cnt !== 4'd1 || dut.state !== COUNT) begin
      tests_failed++;
      $display("FAIL fire_edge_next_run: got count=%0d state=%0d want 1/%0d",
               cnt, dut.state, COUNT);
    end
  endtask

  task automatic test_reset_mid_run();
    pulse();
    tests_run++;
    if (cnt !== 4'd2 || dut.state !== COUNT) begin
      tests_failed++;
      $display("FAIL midrst_setup: got count=%0d state=%0d want 2/%0d", cnt, dut.state, COUNT);
    end
    #2;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (fire !== 1'b0 || cnt !== 4'd0 || dut.state !== IDLE) begin
      tests_failed++;
      $display("FAIL midrst_async: got fire=%b count=%0d state=%0d want 0/0/%0d",
               fire, cnt, dut.state, IDLE);
    end
    step(1);
    rst_n = 1'b1;
    step(1);
    tests_run++;
    if (dut.state !== ARM || cnt !== 4'd0) begin
      tests_failed++;
      $display("FAIL midrst_resume: got state=%0d count=%0d want %0d/0", dut.state, cnt, ARM);
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    test_reset();
    test_basic_fire();
    test_held_input();
    test_timeout();
    test_enable_vs_edge();
    test_edge_during_fire();
    test_reset_mid_run();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule : tb_test_i5160_sink
